xosera_bus_host: RTL and testbench
==================================

// Module: xosera_bus_host
// PURPOSE
//  Initiator for the Xosera 8-bit 68k-style register bus (cs_n, rd_nwr, bytesel, reg_num[3:0], data[7:0]).
//  Turns one 16-bit register read/write request into one or two timed byte cycles.
//  Used as a host bridge and as the bus driver in benches for xosera_main.
//  Byte order is big-endian: even byte (bytesel=0) carries data[15:8].
// PARAMETERS
//  SETUP_CYCLES   1     address/rd_nwr/bytesel/write data stable before cs_n falls (>=1)
//  STROBE_CYCLES  4     cs_n low time; minimum time when EN_DTACK=1 (>=1)
//  HOLD_CYCLES    1     cs_n high, address and write data still held (>=1)
//  RECOV_CYCLES   2     idle gap after each byte cycle, outputs at idle values (>=1)
//  EN_DTACK       0     1: strobe also waits for bus_dtack_i
//  DTACK_TIMEOUT  64    strobe cycles allowed before abort when EN_DTACK=1
// PORTS
//  clk             in   1   system clock
//  reset_i         in   1   synchronous, active-high reset
//  req_valid_i     in   1   request present
//  req_ready_o     out  1   request accepted when valid&&ready
//  req_write_i     in   1   1=write, 0=read
//  req_bytes_i     in   2   [1]=even/high byte, [0]=odd/low byte; 2'b00 is illegal
//  req_reg_num_i   in   4   register number
//  req_data_i      in   16  write data
//  rsp_valid_o     out  1   one-cycle completion pulse
//  rsp_data_o      out  16  read data; bytes not accessed read 0
//  rsp_err_o       out  1   DTACK timeout occurred; qualified by rsp_valid_o
//  bus_cs_n_o      out  1   chip select, active low
//  bus_rd_nwr_o    out  1   1=read, 0=write
//  bus_bytesel_o   out  1   0=even, 1=odd
//  bus_reg_num_o   out  4   register number
//  bus_data_o      out  8   write data
//  bus_data_oe_o   out  1   drive enable for bus_data_o
//  bus_data_i      in   8   read data from bus
//  bus_dtack_i     in   1   DTACK, active low; ignored when EN_DTACK=0
// BEHAVIOUR
//  Outputs at reset and idle: cs_n=1, rd_nwr=1, bytesel=0, reg_num=0, data_o=0, oe=0,
//   rsp_valid=0, rsp_data=0, rsp_err=0. req_ready_o=1 only in IDLE, so it is 1 on the first cycle after reset.
//  All bus outputs are registered. Nothing combinational runs from bus_*_i to any output.
//  FSM: IDLE->SETUP->STROBE->HOLD->RECOV->(SETUP of next byte | DONE)->IDLE. DONE lasts 1 cycle and pulses rsp_valid_o.
//  Accepting a request latches all req_* fields. The first byte is even if req_bytes_i[1]=1, otherwise odd.
//  SETUP: cs_n=1; reg_num, rd_nwr, bytesel valid. On writes, data_o holds the selected byte and oe=1.
//  STROBE: cs_n=0 for STROBE_CYCLES. With EN_DTACK=1 it extends until dtack_i=0 has been sampled.
//  Read data: bus_data_i is sampled on the last STROBE cycle into the matching byte of rsp_data.
//  HOLD: cs_n=1; address, rd_nwr, data_o and oe are unchanged.
//  RECOV: all bus outputs return to idle values, so oe=0 and rd_nwr=1.
//  oe is never 1 while rd_nwr=1, and never 1 during a read request.
//  Per-byte length = SETUP+STROBE+HOLD+RECOV cycles. With defaults this is 8.
//  Latency with defaults, accept edge = cycle 0:
//   - word request (2'b11): rsp_valid_o is high in cycle 17.
//   - single-byte request: rsp_valid_o is high in cycle 9.
//  DTACK timeout: after DTACK_TIMEOUT strobe cycles, the strobe ends and the FSM goes to HOLD.
//   The remaining byte of that request is skipped and rsp_err=1 at DONE.
//  rsp_data/rsp_err hold their values until the next accept, which clears them.
//  req_bytes_i=2'b00: accepted, no bus cycle, DONE on the next cycle with rsp_err=1.
//  req_valid_i while busy: ignored (ready=0); the requester must hold it.
//  reset_i mid-cycle: the next cycle shows idle bus values and IDLE state, and no rsp_valid is issued for the aborted request.
//  Counter is one down-counter, width $clog2(max(all cycle parameters, DTACK_TIMEOUT))+1.
//   It is loaded on each state entry; the state advances at count 0.
// STRUCTURE
//  Additions to xosera_pkg (xv), which already has CS_ENABLED/RnW_READ/RnW_WRITE:
//   - typedef enum logic [2:0] host_state_t {H_IDLE,H_SETUP,H_STROBE,H_HOLD,H_RECOV,H_DONE}
//   - constants BYTESEL_EVEN=1'b0 and BYTESEL_ODD=1'b1
//  No sub-module; FSM and counter stay in this file.
// TESTING
//  Word write reg 3, data 16'hA55A, default timing:
//   -> two strobes of 4 cycles each, bytesel 0 then 1, data_o A5 then 5A.
//   -> oe=1 only in SETUP..HOLD; rsp_valid_o high in cycle 17; rsp_err=0.
//  Word read reg 5, model returns 8'h12 (even) and 8'h34 (odd):
//   -> rsp_data=16'h1234, oe=0 throughout, rd_nwr=1 throughout.
//  Byte-only reads:
//   -> req_bytes=2'b01 returning 8'hC3: one strobe, bytesel=1, rsp_data=16'h00C3, rsp_valid_o in cycle 9.
//   -> req_bytes=2'b10: only the even byte is accessed.
//  EN_DTACK=1, dtack asserted after 7 strobe cycles:
//   -> strobe lasts 7 cycles; rsp_err=0.
//  EN_DTACK=1, dtack never asserted, DTACK_TIMEOUT=8:
//   -> strobe lasts 8 cycles, second byte skipped, rsp_err=1.
//  Back-to-back requests with req_valid held:
//   -> the second is accepted the cycle after DONE.
//   -> reset_i during the first STROBE: next cycle cs_n=1, oe=0, ready=1, no rsp_valid.

Source files
------------

// File: rtl/xosera_pkg.sv
// Shared Xosera bus encodings and host bridge state type.
// Bus polarities are named here so RTL reads in terms of intent, not raw bits.
package xosera_pkg;

  localparam logic CS_ENABLED   = 1'b0;
  localparam logic CS_DISABLED  = 1'b1;
  localparam logic RnW_READ     = 1'b1;
  localparam logic RnW_WRITE    = 1'b0;
  localparam logic BYTESEL_EVEN = 1'b0;
  localparam logic BYTESEL_ODD  = 1'b1;

  typedef enum logic [2:0] {
    H_IDLE,
    H_SETUP,
    H_STROBE,
    H_HOLD,
    H_RECOV,
    H_DONE
  } host_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xosera_bus_host.sv
// Host-side initiator for the Xosera 8-bit register bus: one 16-bit request
// becomes one or two timed byte cycles (even byte carries data[15:8]).
module xosera_bus_host
  import xosera_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int RECOV_CYCLES  = 2,
  parameter bit EN_DTACK      = 1'b0,
  parameter int DTACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_bytes_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic        bus_bytesel_o,
  output logic [3:0]  bus_reg_num_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_dtack_i
);

  localparam int MAX_CYC = imax(imax(imax(SETUP_CYCLES, STROBE_CYCLES),
                                     imax(HOLD_CYCLES, RECOV_CYCLES)), DTACK_TIMEOUT);
  localparam int CW = $clog2(MAX_CYC) + 1;
  // With DTACK the strobe counter runs from DTACK_TIMEOUT-1; at or below this
  // count the minimum strobe width has been met.
  localparam logic [CW-1:0] STB_MIN_CNT = CW'(imax(DTACK_TIMEOUT - STROBE_CYCLES, 0));

  host_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_odd, w_odd_nxt;
  logic          r_two;
  logic          r_write;
  logic [3:0]    r_reg_num;
  logic [15:0]   r_wdata;
  logic          r_dtack_seen;

  logic          r_cs_n, r_rd_nwr, r_bytesel, r_oe;
  logic [3:0]    r_bus_reg;
  logic [7:0]    r_bus_dat;
  logic          r_rsp_valid, r_rsp_err;
  logic [15:0]   r_rsp_data;

  logic          w_accept, w_strobe_end, w_timeout, w_dtack_ok, w_active;
  logic          w_write;
  logic [3:0]    w_reg_num;
  logic [15:0]   w_wdata;

  function automatic logic [CW-1:0] cnt_load(input host_state_t s);
    case (s)
      H_SETUP:  cnt_load = CW'(SETUP_CYCLES - 1);
      H_STROBE: cnt_load = EN_DTACK ? CW'(DTACK_TIMEOUT - 1) : CW'(STROBE_CYCLES - 1);
      H_HOLD:   cnt_load = CW'(HOLD_CYCLES - 1);
      H_RECOV:  cnt_load = CW'(RECOV_CYCLES - 1);
      default:  cnt_load = '0;
    endcase
  endfunction

  assign w_accept = (r_state == H_IDLE) && req_valid_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_odd_nxt    = r_odd;
    w_cnt_nxt    = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
    w_strobe_end = 1'b0;
    w_timeout    = 1'b0;
    w_dtack_ok   = r_dtack_seen || (bus_dtack_i == 1'b0);
    case (r_state)
      H_IDLE: begin
        if (req_valid_i) begin
          if (req_bytes_i == 2'b00) begin
            w_state_nxt = H_DONE;
          end else begin
            w_state_nxt = H_SETUP;
            w_odd_nxt   = req_bytes_i[1] ? BYTESEL_EVEN : BYTESEL_ODD;
          end
        end
      end
      H_SETUP:  if (r_cnt == '0) w_state_nxt = H_STROBE;
      H_STROBE: begin
        if (EN_DTACK) begin
          if (w_dtack_ok && (r_cnt <= STB_MIN_CNT)) begin
            w_strobe_end = 1'b1;
          end else if (r_cnt == '0) begin
            w_strobe_end = 1'b1;
            w_timeout    = 1'b1;
          end
        end else if (r_cnt == '0) begin
          w_strobe_end = 1'b1;
        end
        if (w_strobe_end) w_state_nxt = H_HOLD;
      end
      H_HOLD:   if (r_cnt == '0) w_state_nxt = H_RECOV;
      H_RECOV: begin
        if (r_cnt == '0) begin
          // a timed-out first byte abandons the rest of the word
          if (r_two && (r_odd == BYTESEL_EVEN) && !r_rsp_err) begin
            w_state_nxt = H_SETUP;
            w_odd_nxt   = BYTESEL_ODD;
          end else begin
            w_state_nxt = H_DONE;
          end
        end
      end
      H_DONE:   w_state_nxt = H_IDLE;
      default:  w_state_nxt = H_IDLE;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = cnt_load(w_state_nxt);
  end

  assign w_write   = w_accept ? req_write_i   : r_write;
  assign w_reg_num = w_accept ? req_reg_num_i : r_reg_num;
  assign w_wdata   = w_accept ? req_data_i    : r_wdata;
  assign w_active  = (w_state_nxt == H_SETUP) || (w_state_nxt == H_STROBE) ||
                     (w_state_nxt == H_HOLD);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state      <= H_IDLE;
      r_cnt        <= '0;
      r_odd        <= BYTESEL_EVEN;
      r_two        <= 1'b0;
      r_write      <= 1'b0;
      r_reg_num    <= '0;
      r_wdata      <= '0;
      r_dtack_seen <= 1'b0;
      r_cs_n       <= CS_DISABLED;
      r_rd_nwr     <= RnW_READ;
      r_bytesel    <= BYTESEL_EVEN;
      r_bus_reg    <= '0;
      r_bus_dat    <= '0;
      r_oe         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_odd        <= w_odd_nxt;
      r_dtack_seen <= (r_state == H_STROBE) && !w_strobe_end && w_dtack_ok;
      r_cs_n       <= (w_state_nxt == H_STROBE) ? CS_ENABLED : CS_DISABLED;
      r_rd_nwr     <= (w_active && w_write) ? RnW_WRITE : RnW_READ;
      r_bytesel    <= w_active ? w_odd_nxt : BYTESEL_EVEN;
      r_bus_reg    <= w_active ? w_reg_num : 4'h0;
      r_bus_dat    <= (w_active && w_write) ? (w_odd_nxt ? w_wdata[7:0] : w_wdata[15:8]) : 8'h00;
      r_oe         <= w_active && w_write;
      r_rsp_valid  <= (w_state_nxt == H_DONE);
      if (w_accept) begin
        r_two      <= &req_bytes_i;
        r_write    <= req_write_i;
        r_reg_num  <= req_reg_num_i;
        r_wdata    <= req_data_i;
        r_rsp_data <= '0;
        r_rsp_err  <= (req_bytes_i == 2'b00);
      end else begin
        if (w_strobe_end && !r_write) begin
          if (r_odd) r_rsp_data[7:0]  <= bus_data_i;
          else       r_rsp_data[15:8] <= bus_data_i;
        end
        if (w_timeout) r_rsp_err <= 1'b1;
      end
    end
  end

  assign req_ready_o   = (r_state == H_IDLE);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_data_o    = r_rsp_data;
  assign rsp_err_o     = r_rsp_err;
  assign bus_cs_n_o    = r_cs_n;
  assign bus_rd_nwr_o  = r_rd_nwr;
  assign bus_bytesel_o = r_bytesel;
  assign bus_reg_num_o = r_bus_reg;
  assign bus_data_o    = r_bus_dat;
  assign bus_data_oe_o = r_oe;

endmodule

// File: tb/tb_xosera_bus_host.sv
// Directed bench for xosera_bus_host: default-timing instance plus a DTACK
// instance (EN_DTACK=1, DTACK_TIMEOUT=8) driven by a small bus responder.
module tb_xosera_bus_host;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid, b_valid, req_write;
  logic [1:0]  req_bytes;
  logic [3:0]  req_reg;
  logic [15:0] req_data;
  logic [7:0]  rd_even, rd_odd;
  logic        b_dtack_n;
  logic        sel;

  logic        a_ready, a_rsp_valid, a_rsp_err, a_cs_n, a_rd_nwr, a_bytesel, a_oe;
  logic [15:0] a_rsp_data;
  logic [3:0]  a_reg_num;
  logic [7:0]  a_data_o, a_data_i;
  logic        b_ready, b_rsp_valid, b_rsp_err, b_cs_n, b_rd_nwr, b_bytesel, b_oe;
  logic [15:0] b_rsp_data;
  logic [3:0]  b_reg_num;
  logic [7:0]  b_data_o, b_data_i;

  assign a_data_i = a_bytesel ? rd_odd : rd_even;
  assign b_data_i = b_bytesel ? rd_odd : rd_even;

  xosera_bus_host u_dut (
    .clk(clk), .reset_i(reset),
    .req_valid_i(a_valid), .req_ready_o(a_ready), .req_write_i(req_write),
    .req_bytes_i(req_bytes), .req_reg_num_i(req_reg), .req_data_i(req_data),
    .rsp_valid_o(a_rsp_valid), .rsp_data_o(a_rsp_data), .rsp_err_o(a_rsp_err),
    .bus_cs_n_o(a_cs_n), .bus_rd_nwr_o(a_rd_nwr), .bus_bytesel_o(a_bytesel),
    .bus_reg_num_o(a_reg_num), .bus_data_o(a_data_o), .bus_data_oe_o(a_oe),
    .bus_data_i(a_data_i), .bus_dtack_i(1'b1)
  );

  xosera_bus_host #(.EN_DTACK(1'b1), .DTACK_TIMEOUT(8)) u_dtk (
    .clk(clk), .reset_i(reset),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_write_i(req_write),
    .req_bytes_i(req_bytes), .req_reg_num_i(req_reg), .req_data_i(req_data),
    .rsp_valid_o(b_rsp_valid), .rsp_data_o(b_rsp_data), .rsp_err_o(b_rsp_err),
    .bus_cs_n_o(b_cs_n), .bus_rd_nwr_o(b_rd_nwr), .bus_bytesel_o(b_bytesel),
    .bus_reg_num_o(b_reg_num), .bus_data_o(b_data_o), .bus_data_oe_o(b_oe),
    .bus_data_i(b_data_i), .bus_dtack_i(b_dtack_n)
  );

  logic        m_ready, m_rsp_valid, m_rsp_err, m_cs_n, m_rd_nwr, m_bytesel, m_oe;
  logic [15:0] m_rsp_data_w;
  logic [3:0]  m_reg_num;
  logic [7:0]  m_data_o;
  assign m_ready      = sel ? b_ready     : a_ready;
  assign m_rsp_valid  = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_err    = sel ? b_rsp_err   : a_rsp_err;
  assign m_rsp_data_w = sel ? b_rsp_data  : a_rsp_data;
  assign m_cs_n       = sel ? b_cs_n      : a_cs_n;
  assign m_rd_nwr     = sel ? b_rd_nwr    : a_rd_nwr;
  assign m_bytesel    = sel ? b_bytesel   : a_bytesel;
  assign m_oe         = sel ? b_oe        : a_oe;
  assign m_reg_num    = sel ? b_reg_num   : a_reg_num;
  assign m_data_o     = sel ? b_data_o    : a_data_o;

  int n_vec = 0;
  int n_bad = 0;

  int          m_strobes, m_oe_cyc, m_rdlow_cyc, m_oe_bad, m_busy_rdy, m_rsp_cyc;
  int          m_len [2];
  logic        m_bsel [2];
  logic [7:0]  m_dout [2];
  logic [3:0]  m_reg [2];
  logic [15:0] m_rsp_data;
  logic        m_rsp_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge and record what the bus does
  // until rsp_valid; cycle 1 is the cycle right after the accept edge.
  task automatic do_req(input bit dut, input bit wr, input logic [1:0] bytes,
                        input logic [3:0] rn, input logic [15:0] wd,
                        input int dtack_at, input bit hold_v);
    int  cyc;
    int  idx;
    bit  prev_cs;
    bit  done;
    sel = dut;
    req_write = wr; req_bytes = bytes; req_reg = rn; req_data = wd;
    if (dut) b_valid = 1'b1; else a_valid = 1'b1;
    #1;
    check("ready_at_request", {31'd0, m_ready}, 32'd1);
    m_strobes = 0; m_oe_cyc = 0; m_rdlow_cyc = 0; m_oe_bad = 0; m_busy_rdy = 0;
    m_rsp_cyc = -1; m_len[0] = 0; m_len[1] = 0;
    m_bsel[0] = 1'bx; m_bsel[1] = 1'bx; m_dout[0] = 'x; m_dout[1] = 'x;
    m_reg[0] = 'x; m_reg[1] = 'x; m_rsp_data = 'x; m_rsp_e = 1'bx;
    @(posedge clk);
    cyc = 0; prev_cs = 1'b1; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold_v) begin a_valid = 1'b0; b_valid = 1'b0; end
      if (m_cs_n == 1'b0) begin
        if (prev_cs) m_strobes++;
        if (m_strobes >= 1 && m_strobes <= 2) begin
          idx = m_strobes - 1;
          m_len[idx]++;
          m_bsel[idx] = m_bytesel;
          m_dout[idx] = m_data_o;
          m_reg[idx]  = m_reg_num;
          if (dtack_at != 0 && m_len[idx] >= dtack_at) b_dtack_n = 1'b0;
        end
      end else begin
        b_dtack_n = 1'b1;
      end
      prev_cs = m_cs_n;
      if (m_oe) m_oe_cyc++;
      if (!m_rd_nwr) m_rdlow_cyc++;
      if (m_oe && m_rd_nwr) m_oe_bad++;
      if (m_ready) m_busy_rdy++;
      if (m_rsp_valid) begin
        done = 1'b1;
        m_rsp_cyc = cyc;
        m_rsp_data = m_rsp_data_w;
        m_rsp_e = m_rsp_err;
      end
    end
    check("rsp_within_budget", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("ready_after_done", {31'd0, m_ready}, 32'd1);
    check("rsp_valid_one_cycle", {31'd0, m_rsp_valid}, 32'd0);
    check("rsp_data_held", {16'd0, m_rsp_data_w}, {16'd0, m_rsp_data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv, cl;
    a_valid = 0; b_valid = 0; req_write = 0; req_bytes = 0; req_reg = 0; req_data = 0;
    rd_even = 0; rd_odd = 0; b_dtack_n = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("reset_bus_a", {13'd0, a_cs_n, a_rd_nwr, a_bytesel, a_reg_num, a_data_o, a_oe,
                          a_rsp_valid, a_rsp_err, a_ready}, 32'b11_0_0000_00000000_0_0_0_1);
    check("reset_rsp_data_a", {16'd0, a_rsp_data}, 32'h0);
    check("reset_bus_b", {13'd0, b_cs_n, b_rd_nwr, b_bytesel, b_reg_num, b_data_o, b_oe,
                          b_rsp_valid, b_rsp_err, b_ready}, 32'b11_0_0000_00000000_0_0_0_1);

    // word write reg 3, A55A
    do_req(0, 1, 2'b11, 4'd3, 16'hA55A, 0, 0);
    check("ww_strobes", m_strobes, 2);
    check("ww_len0", m_len[0], 4);
    check("ww_len1", m_len[1], 4);
    check("ww_bsel", {30'd0, m_bsel[0], m_bsel[1]}, 32'b01);
    check("ww_dout", {16'd0, m_dout[0], m_dout[1]}, 32'hA55A);
    check("ww_reg", {24'd0, m_reg[0], m_reg[1]}, 32'h33);
    check("ww_oe_cycles", m_oe_cyc, 12);
    check("ww_write_cycles", m_rdlow_cyc, 12);
    check("ww_oe_with_read", m_oe_bad, 0);
    check("ww_ready_busy", m_busy_rdy, 0);
    check("ww_rsp_cycle", m_rsp_cyc, 17);
    check("ww_rsp_err", {31'd0, m_rsp_e}, 0);

    // word read reg 5
    rd_even = 8'h12; rd_odd = 8'h34;
    do_req(0, 0, 2'b11, 4'd5, 16'hFFFF, 0, 0);
    check("wr_rsp_data", {16'd0, m_rsp_data}, 32'h1234);
    check("wr_oe_cycles", m_oe_cyc, 0);
    check("wr_write_cycles", m_rdlow_cyc, 0);
    check("wr_strobes", m_strobes, 2);
    check("wr_rsp_cycle", m_rsp_cyc, 17);
    check("wr_reg", {24'd0, m_reg[0], m_reg[1]}, 32'h55);

    // odd byte only
    rd_even = 8'hEE; rd_odd = 8'hC3;
    do_req(0, 0, 2'b01, 4'd9, 16'h0, 0, 0);
    check("bo_strobes", m_strobes, 1);
    check("bo_bsel", {31'd0, m_bsel[0]}, 1);
    check("bo_rsp_data", {16'd0, m_rsp_data}, 32'h00C3);
    check("bo_rsp_cycle", m_rsp_cyc, 9);

    // even byte only
    rd_even = 8'h9B; rd_odd = 8'h77;
    do_req(0, 0, 2'b10, 4'd1, 16'h0, 0, 0);
    check("be_strobes", m_strobes, 1);
    check("be_bsel", {31'd0, m_bsel[0]}, 0);
    check("be_rsp_data", {16'd0, m_rsp_data}, 32'h9B00);
    check("be_rsp_cycle", m_rsp_cyc, 9);

    // illegal empty byte mask
    do_req(0, 0, 2'b00, 4'd2, 16'h0, 0, 0);
    check("z_strobes", m_strobes, 0);
    check("z_rsp_cycle", m_rsp_cyc, 1);
    check("z_rsp_err", {31'd0, m_rsp_e}, 1);
    check("z_rsp_data", {16'd0, m_rsp_data}, 0);

    // back-to-back with valid held through the first request
    rd_even = 8'h56; rd_odd = 8'h78;
    do_req(0, 0, 2'b11, 4'd4, 16'h0, 0, 1);
    check("bb1_rsp_data", {16'd0, m_rsp_data}, 32'h5678);
    check("bb1_err_cleared", {31'd0, m_rsp_e}, 0);
    check("bb1_strobes", m_strobes, 2);
    check("bb1_ready_busy", m_busy_rdy, 0);
    do_req(0, 1, 2'b01, 4'd2, 16'h00BE, 0, 0);
    check("bb2_strobes", m_strobes, 1);
    check("bb2_dout", {24'd0, m_dout[0]}, 32'hBE);
    check("bb2_rsp_cycle", m_rsp_cyc, 9);

    // DTACK never asserted: timeout after 8 strobe cycles, second byte skipped
    do_req(1, 0, 2'b11, 4'd6, 16'h0, 0, 0);
    check("to_strobes", m_strobes, 1);
    check("to_len", m_len[0], 8);
    check("to_rsp_cycle", m_rsp_cyc, 13);
    check("to_rsp_err", {31'd0, m_rsp_e}, 1);

    // DTACK arrives in the 7th strobe cycle of each byte
    do_req(1, 1, 2'b11, 4'd7, 16'hC0DE, 7, 0);
    check("dk_strobes", m_strobes, 2);
    check("dk_len0", m_len[0], 7);
    check("dk_len1", m_len[1], 7);
    check("dk_dout", {16'd0, m_dout[0], m_dout[1]}, 32'hC0DE);
    check("dk_rsp_cycle", m_rsp_cyc, 23);
    check("dk_rsp_err", {31'd0, m_rsp_e}, 0);

    // early DTACK still honours the minimum strobe width
    rd_even = 8'h4D;
    do_req(1, 0, 2'b10, 4'd1, 16'h0, 1, 0);
    check("dm_len", m_len[0], 4);
    check("dm_rsp_data", {16'd0, m_rsp_data}, 32'h4D00);
    check("dm_rsp_cycle", m_rsp_cyc, 9);

    // reset during the first strobe
    sel = 1'b0; req_write = 1'b1; req_bytes = 2'b11; req_reg = 4'd8; req_data = 16'h1357;
    a_valid = 1'b1;
    @(posedge clk);
    cl = 0;
    for (int i = 0; i < 10 && cl == 0; i++) begin
      @(negedge clk);
      a_valid = 1'b0;
      if (a_cs_n == 1'b0) cl = 1;
    end
    check("rst_reached_strobe", cl, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_bus_idle", {29'd0, a_cs_n, a_oe, a_ready}, 32'b101);
    check("rst_no_rsp", {31'd0, a_rsp_valid}, 0);
    rv = 0; cl = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_rsp_valid) rv++;
      if (!a_cs_n) cl++;
    end
    check("rst_no_late_rsp", rv, 0);
    check("rst_no_late_strobe", cl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
